// File: rtl/acesso_memoria_pkg.sv
// Shared definitions for the memory-access stage: state encoding, widths, alignment helper.
package acesso_memoria_pkg;

  localparam int unsigned DATA_W_DEF  = 64;
  localparam int unsigned TIMEOUT_DEF = 16;
  localparam int unsigned ALIGN_BITS  = 3;
  // Wide enough for the largest legal TIMEOUT (255).
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StFin  = 2'd2,
    StErr  = 2'd3
  } state_e;

  // A doubleword access is legal only when the low address bits are zero.
  function automatic logic is_aligned(input logic [ALIGN_BITS-1:0] lsb);
    return (lsb == '0);
  endfunction

endpackage

// File: rtl/acesso_memoria_contador_timeout.sv
// Clear/enable counter with a terminal-count flag at TIMEOUT-1, used to bound mem_req.
module contador_timeout
  import acesso_memoria_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next count: clear wins over enable; saturate at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acesso_memoria.sv
// Memory-access stage: one req/ack transaction at a time toward data memory, with
// load writeback register, alignment check and request timeout.
module acesso_memoria
  import acesso_memoria_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              misaligned,
  output logic              timeout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              tout_q, tout_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic cnt_clr, cnt_en, cnt_tc;

  contador_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_contador_timeout (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  // Next-state, capture and counter control; ack takes priority over timeout.
  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    tout_d    = tout_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_aligned(addr[ALIGN_BITS-1:0])) begin
            addr_d    = addr;
            wdata_d   = wdata;
            mem_we_d  = is_store;
            mem_req_d = 1'b1;
            tout_d    = 1'b0;
            cnt_clr   = 1'b1;
            state_d   = StReq;
          end else begin
            state_d = StErr;
          end
        end
      end
      StReq: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          // mem_we_q still holds the captured direction here.
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
          state_d = StFin;
        end else if (cnt_tc) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          tout_d    = 1'b1;
          state_d   = StFin;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StFin: begin
        tout_d  = 1'b0;
        state_d = StIdle;
      end
      StErr: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and capture registers, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      tout_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      tout_q    <= tout_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // Status outputs decoded from state; flags are zero outside the done cycle.
  always_comb begin
    busy       = (state_q != StIdle);
    done       = (state_q == StFin) || (state_q == StErr);
    misaligned = (state_q == StErr);
    timeout    = (state_q == StFin) && tout_q;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_acesso_memoria.sv
// Bench for acesso_memoria: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_acesso_memoria;

  localparam int unsigned DW = 64;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          is_store = 1'b0;
  logic [DW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  logic          busy, done, misaligned, timeout, mem_req, mem_we;
  logic [DW-1:0] rdata, mem_addr, mem_wdata;

  acesso_memoria #(
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .misaligned(misaligned),
    .timeout   (timeout),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request lives for 'age' edges; a completion shows as a single
  // pulse in the cycle after it is decided.
  bit            m_busy, m_req, m_we, m_done, m_mis, m_to;
  int            m_age;
  logic [DW-1:0] m_rdata = '0, m_addr = '0, m_wdata = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy  <= 0; m_req <= 0; m_we <= 0; m_done <= 0; m_mis <= 0; m_to <= 0;
      m_age   <= 0;
      m_rdata <= '0; m_addr <= '0; m_wdata <= '0;
    end else if (m_done) begin
      m_done <= 0; m_mis <= 0; m_to <= 0; m_busy <= 0;
    end else if (m_req) begin
      m_age <= m_age + 1;
      if (mem_ack) begin
        m_req  <= 0;
        m_done <= 1;
        if (!m_we) m_rdata <= mem_rdata;
      end else if (m_age + 1 == int'(TO)) begin
        m_req  <= 0;
        m_done <= 1;
        m_to   <= 1;
      end
    end else if (start) begin
      m_busy <= 1;
      if (addr % 8 != 0) begin
        m_done <= 1;
        m_mis  <= 1;
      end else begin
        m_req   <= 1;
        m_age   <= 0;
        m_we    <= is_store;
        m_addr  <= addr;
        m_wdata <= wdata;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", busy, m_busy);
      chk("m_done", done, m_done);
      chk("m_misaligned", misaligned, m_mis);
      chk("m_timeout", timeout, m_to);
      chk("m_mem_req", mem_req, m_req);
      if (m_req) chk("m_mem_we", mem_we, m_we);
      chk("m_rdata", rdata, m_rdata);
      chk("m_mem_addr", mem_addr, m_addr);
      chk("m_mem_wdata", mem_wdata, m_wdata);
    end
  end

  int n_hi;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Load, zero wait
    start = 1; is_store = 0; addr = 64'h40;
    @(negedge clk);
    start = 0;
    chk("t1_req", mem_req, 1);
    chk("t1_we", mem_we, 0);
    chk("t1_addr", mem_addr, 64'h40);
    chk("t1_done_early", done, 0);
    mem_ack = 1; mem_rdata = 64'hDEADBEEF_00000001;
    @(negedge clk);
    mem_ack = 0;
    chk("t1_done", done, 1);
    chk("t1_req_drop", mem_req, 0);
    chk("t1_rdata", rdata, 64'hDEADBEEF_00000001);
    chk("t1_to", timeout, 0);
    chk("t1_mis", misaligned, 0);
    @(negedge clk);
    chk("t1_idle", busy, 0);

    // Store, 3 wait states
    start = 1; is_store = 1; addr = 64'h1000; wdata = 64'h0123456789ABCDEF;
    @(negedge clk);
    start = 0; addr = '0; wdata = '0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", mem_req, 1);
      chk("t2_we", mem_we, 1);
      chk("t2_addr", mem_addr, 64'h1000);
      chk("t2_wdata", mem_wdata, 64'h0123456789ABCDEF);
      chk("t2_no_done", done, 0);
      if (i == 3) begin
        mem_ack = 1; mem_rdata = 64'hFFFF0000FFFF0000;
      end
      @(negedge clk);
    end
    mem_ack = 0;
    chk("t2_done", done, 1);
    chk("t2_req_drop", mem_req, 0);
    chk("t2_rdata_kept", rdata, 64'hDEADBEEF_00000001);
    @(negedge clk);

    // Misaligned
    start = 1; is_store = 0; addr = 64'h43;
    @(negedge clk);
    start = 0;
    chk("t3_done", done, 1);
    chk("t3_mis", misaligned, 1);
    chk("t3_req", mem_req, 0);
    chk("t3_busy", busy, 1);
    @(negedge clk);
    chk("t3_busy_end", busy, 0);
    chk("t3_mis_end", misaligned, 0);
    chk("t3_rdata_kept", rdata, 64'hDEADBEEF_00000001);

    // Timeout, no ack
    start = 1; is_store = 0; addr = 64'h2000;
    @(negedge clk);
    start = 0;
    n_hi  = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      if (mem_req) n_hi++;
      @(negedge clk);
    end
    chk("t4_done_seen", done, 1);
    chk("t4_req_cycles", n_hi, TO);
    chk("t4_to", timeout, 1);
    chk("t4_rdata_kept", rdata, 64'hDEADBEEF_00000001);
    @(negedge clk);
    // Normal access after the timeout, one wait state
    start = 1; is_store = 0; addr = 64'h2008;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 64'h5555AAAA_12345678;
    @(negedge clk);
    mem_ack = 0;
    chk("t4b_done", done, 1);
    chk("t4b_to", timeout, 0);
    chk("t4b_rdata", rdata, 64'h5555AAAA_12345678);
    @(negedge clk);

    // start held high throughout an access
    start = 1; is_store = 1; addr = 64'h3000; wdata = 64'hCAFE;
    @(negedge clk);
    chk("t5_req", mem_req, 1);
    addr = 64'h3008; wdata = 64'hBEEF;
    @(negedge clk);
    chk("t5_hold_addr", mem_addr, 64'h3000);
    chk("t5_hold_wdata", mem_wdata, 64'hCAFE);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    chk("t5_done", done, 1);
    chk("t5_req_fin", mem_req, 0);
    @(negedge clk);
    chk("t5_fin_ignored", busy, 0);
    chk("t5_fin_no_req", mem_req, 0);
    @(negedge clk);
    start = 0;
    chk("t5_reaccept", mem_req, 1);
    chk("t5_new_addr", mem_addr, 64'h3008);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    chk("t5_done2", done, 1);
    @(negedge clk);

    // Reset in the middle of a request, late ack afterwards
    start = 1; is_store = 0; addr = 64'h4000;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("t6_req", mem_req, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("t6_req", mem_req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rdata", rdata, 0);
    chk("t6_addr", mem_addr, 0);
    mem_ack = 1; mem_rdata = 64'h0000_1234_5678_9ABC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_done", done, 0);
      chk("t6_no_busy", busy, 0);
      chk("t6_rdata_zero", rdata, 0);
    end
    mem_ack = 0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
